// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//   Time-multiplexed fixed-point neuron. Each accepted input triggers one
//   weight read and one multiply-accumulate. After the last input, the bias
//   is read and added, and the sum is rescaled and saturated to DATA_W. The
//   activation is then applied and the result is offered on a valid/ready
//   output.
//
//   Build option: define NEURON_RELU_EN to clamp negative results to zero
//   (hidden layers). With it undefined the output is linear (output layer).
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, neuron_id      begin an evaluation (IDLE only); neuron index
//   in_valid/in_ready     input activation handshake, in_data
//   wt_en/wt_addr         weight read strobe and address {neuron, idx}
//   wt_data               weight, valid the cycle after wt_en
//   bias_en/bias_addr     bias read strobe and address (neuron index)
//   bias_data             bias, valid the cycle after bias_en
//   out_valid/out_ready   result handshake, out_data, out_sat (saturated)
//   busy                  evaluation in progress
module neuron_mac_seq #(
  parameter int DATA_W      = 16,
  parameter int FRAC_BITS   = 8,
  parameter int N_INPUTS    = 784,
  parameter int NEURON_ID_W = 8,
  parameter int ACC_W       = 48,
  parameter int IDX_W       = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NEURON_ID_W-1:0]       neuron_id,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         wt_en,
  output logic [NEURON_ID_W+IDX_W-1:0] wt_addr,
  input  logic [DATA_W-1:0]            wt_data,
  output logic                         bias_en,
  output logic [NEURON_ID_W-1:0]       bias_addr,
  input  logic [DATA_W-1:0]            bias_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sat,
  output logic                         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_BIAS,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    state, state_nxt;
  logic [NEURON_ID_W-1:0]    nid;
  logic [IDX_W-1:0]          idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  d_reg;
  logic                      pending;
  logic                      accept;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    sum_s;
  logic signed [ACC_W-1:0]    sum_r;
  logic [DATA_W-1:0]          res;
  logic                       res_sat;

  assign wt_addr   = {nid, idx};
  assign bias_addr = nid;

  // Control: next state and strobes. Strobes are also masked by reset so an
  // abandoned evaluation issues no read in the reset cycle itself.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    bias_en   = 1'b0;
    out_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: begin
        in_ready = ~reset;
        if (in_valid && !reset && idx == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bias_en   = ~reset;
        state_nxt = S_BIAS;
      end
      S_BIAS:  state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    accept = in_valid & in_ready;
    wt_en  = accept;
  end

  // Datapath: product of the registered sample with the weight now arriving,
  // then bias alignment, rescale (floor) and saturation.
  always_comb begin
    prod     = d_reg * $signed(wt_data);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W){bias_data[DATA_W-1]}}, bias_data};
    sum_s    = acc + (bias_ext <<< FRAC_BITS);
    sum_r    = sum_s >>> FRAC_BITS;
    res      = sum_r[DATA_W-1:0];
    res_sat  = 1'b0;
    if (sum_r > SAT_MAX) begin
      res     = SAT_MAX[DATA_W-1:0];
      res_sat = 1'b1;
    end else if (sum_r < SAT_MIN) begin
      res     = SAT_MIN[DATA_W-1:0];
      res_sat = 1'b1;
    end
`ifdef NEURON_RELU_EN
    if (res[DATA_W-1]) res = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      nid      <= '0;
      idx      <= '0;
      acc      <= '0;
      d_reg    <= '0;
      pending  <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= accept;
      if (pending) acc <= acc + prod_ext;
      if (accept) begin
        d_reg <= $signed(in_data);
        idx   <= idx + IDX_W'(1);
      end
      // No MAC can be pending in IDLE, so clearing acc here never drops one.
      if (state == S_IDLE && start) begin
        nid <= neuron_id;
        idx <= '0;
        acc <= '0;
      end
      if (state == S_BIAS) begin
        out_data <= res;
        out_sat  <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: four-input neuron
  logic        a_start, a_in_valid, a_in_ready, a_wt_en, a_bias_en;
  logic        a_out_valid, a_out_ready, a_out_sat, a_busy;
  logic [7:0]  a_neuron_id, a_bias_addr;
  logic [9:0]  a_wt_addr;
  logic [15:0] a_in_data, a_wt_data, a_bias_data, a_out_data;

  // Instance B: single-input neuron
  logic        b_start, b_in_valid, b_in_ready, b_wt_en, b_bias_en;
  logic        b_out_valid, b_out_ready, b_out_sat, b_busy;
  logic [7:0]  b_neuron_id, b_bias_addr;
  logic [8:0]  b_wt_addr;
  logic [15:0] b_in_data, b_wt_data, b_bias_data, b_out_data;

  neuron_mac_seq #(.N_INPUTS(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .neuron_id(a_neuron_id),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .wt_en(a_wt_en), .wt_addr(a_wt_addr), .wt_data(a_wt_data),
    .bias_en(a_bias_en), .bias_addr(a_bias_addr), .bias_data(a_bias_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy)
  );

  neuron_mac_seq #(.N_INPUTS(1)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .neuron_id(b_neuron_id),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .wt_en(b_wt_en), .wt_addr(b_wt_addr), .wt_data(b_wt_data),
    .bias_en(b_bias_en), .bias_addr(b_bias_addr), .bias_data(b_bias_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous weight / bias stores
  logic [15:0] wtab [4];
  logic [15:0] in_tab [4];
  logic [15:0] bias_val;
  logic [9:0]  wlog [$];
  logic [7:0]  blog [$];
  logic [8:0]  b_wlog [$];
  logic [7:0]  b_blog [$];

  always @(posedge clk) begin
    if (a_wt_en) begin
      a_wt_data <= wtab[a_wt_addr[1:0]];
      wlog.push_back(a_wt_addr);
    end
    if (a_bias_en) begin
      a_bias_data <= bias_val;
      blog.push_back(a_bias_addr);
    end
    if (b_wt_en) begin
      b_wt_data <= 16'h0100;
      b_wlog.push_back(b_wt_addr);
    end
    if (b_bias_en) begin
      b_bias_data <= 16'h0000;
      b_blog.push_back(b_bias_addr);
    end
  end

  task automatic set_vec(input logic [15:0] i0, i1, i2, i3, w0, w1, w2, w3, b);
    in_tab[0] = i0; in_tab[1] = i1; in_tab[2] = i2; in_tab[3] = i3;
    wtab[0] = w0; wtab[1] = w1; wtab[2] = w2; wtab[3] = w3;
    bias_val = b;
  endtask

  // One evaluation on instance A. stall: in_valid only on odd cycles plus
  // start pulses while busy; hold: cycles of out_ready low after out_valid.
  task automatic run_a(input string tag, input logic [7:0] nid, input bit stall,
                       input int hold, input logic [15:0] exp_data, input logic exp_sat);
    int cyc, sent, lat;
    logic [9:0] exp_addr;
    wlog.delete();
    blog.delete();
    @(negedge clk);
    a_neuron_id = nid;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_neuron_id = 8'h00;
    cyc = 1; sent = 0; lat = -1;
    while (cyc < 100) begin
      if (a_out_valid) begin
        lat = cyc;
        break;
      end
      a_start = stall && (cyc % 3 == 0);
      if (sent < 4 && a_in_ready && !(stall && (cyc % 2 == 0))) begin
        a_in_valid = 1'b1;
        a_in_data = in_tab[sent];
        sent++;
      end else begin
        a_in_valid = 1'b0;
        a_in_data = 16'hDEAD;
      end
      @(negedge clk);
      cyc++;
    end
    a_in_valid = 1'b0;
    a_start = 1'b0;
    check({tag, " latency"}, lat, stall ? 10 : 7);
    check({tag, " out_data"}, a_out_data, exp_data);
    check({tag, " out_sat"}, a_out_sat, exp_sat);
    check({tag, " wt reads"}, wlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      exp_addr = {nid, 2'(i)};
      if (i < wlog.size()) check({tag, " wt_addr"}, wlog[i], exp_addr);
    end
    check({tag, " bias reads"}, blog.size(), 1);
    if (blog.size() > 0) check({tag, " bias_addr"}, blog[0], nid);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " held valid"}, a_out_valid, 1'b1);
      check({tag, " held data"}, a_out_data, exp_data);
    end
    // start during the output handshake cycle must be ignored
    a_out_ready = 1'b1;
    a_start = 1'b1;
    a_neuron_id = nid;
    @(negedge clk);
    a_out_ready = 1'b0;
    a_start = 1'b0;
    check({tag, " idle after out"}, {a_busy, a_out_valid}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, lat, seen;
    reset = 1'b1;
    a_start = 0; a_neuron_id = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_start = 0; b_neuron_id = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    a_wt_data = 0; a_bias_data = 0; b_wt_data = 0; b_bias_data = 0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst out_valid", a_out_valid, 1'b0);
    check("rst out_data", a_out_data, 16'h0000);
    check("rst out_sat", a_out_sat, 1'b0);
    check("rst in_ready", a_in_ready, 1'b0);
    check("rst strobes", {a_wt_en, a_bias_en}, 2'b00);
    check("rst busy", a_busy, 1'b0);
    check("rst wt_addr", a_wt_addr, 10'h000);
    check("rst bias_addr", a_bias_addr, 8'h00);

    set_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100,
            16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0040);
    run_a("basic", 8'h3C, 1'b0, 0, 16'h0240, 1'b0);

    set_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100,
            16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'h0040);
`ifdef NEURON_RELU_EN
    run_a("negative", 8'h12, 1'b0, 0, 16'h0000, 1'b0);
`else
    run_a("negative", 8'h12, 1'b0, 0, 16'hFE40, 1'b0);
`endif

    set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
            16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_a("sat pos", 8'h01, 1'b0, 0, 16'h7FFF, 1'b1);

    set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
            16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF);
`ifdef NEURON_RELU_EN
    run_a("sat neg", 8'h02, 1'b0, 0, 16'h0000, 1'b1);
`else
    run_a("sat neg", 8'h02, 1'b0, 0, 16'h8000, 1'b1);
`endif

    // 1*1 + 1*2 + 2*0.5 + 0.5*(-1) = 3.5
    set_vec(16'h0100, 16'h0100, 16'h0200, 16'h0080,
            16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0000);
    run_a("mixed", 8'hC3, 1'b0, 0, 16'h0380, 1'b0);

    // Raw sum of -1 LSB^2 floors to -1 LSB
    set_vec(16'h0001, 16'h0000, 16'h0000, 16'h0000,
            16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC, 16'h0000);
`ifdef NEURON_RELU_EN
    run_a("floor", 8'h44, 1'b0, 0, 16'h0000, 1'b0);
`else
    run_a("floor", 8'h44, 1'b0, 0, 16'hFFFF, 1'b0);
`endif

    set_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100,
            16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0040);
    run_a("stall", 8'h5A, 1'b1, 5, 16'h0240, 1'b0);

    // Reset after two samples, then a fresh evaluation
    set_vec(16'h7FFF, 16'h7FFF, 16'h0100, 16'h0100,
            16'h7FFF, 16'h7FFF, 16'h0080, 16'h0080, 16'h0040);
    wlog.delete();
    @(negedge clk);
    a_neuron_id = 8'h77; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1; a_in_data = in_tab[i];
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_out_valid || a_busy) seen++;
    end
    check("abort no output", seen, 0);
    check("abort wt reads", wlog.size(), 2);
    set_vec(16'h0100, 16'h0100, 16'h0100, 16'h0100,
            16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0040);
    run_a("after abort", 8'h77, 1'b0, 0, 16'h0240, 1'b0);

    // Single-input instance
    b_wlog.delete();
    b_blog.delete();
    @(negedge clk);
    b_neuron_id = 8'hA5; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_neuron_id = 8'h00;
    check("n1 in_ready", b_in_ready, 1'b1);
    b_in_valid = 1'b1; b_in_data = 16'h0100;
    cyc = 1; lat = -1;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      b_in_valid = 1'b0;
      if (b_out_valid) begin
        lat = cyc;
        break;
      end
    end
    check("n1 latency", lat, 4);
    check("n1 out_data", b_out_data, 16'h0100);
    check("n1 wt reads", b_wlog.size(), 1);
    if (b_wlog.size() > 0) check("n1 wt_addr", b_wlog[0], 9'h14A);
    check("n1 bias reads", b_blog.size(), 1);
    if (b_blog.size() > 0) check("n1 bias_addr", b_blog[0], 8'hA5);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    check("n1 idle", b_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Parametrised, time-multiplexed fixed-point neuron for the MLP datapath. One multiply-accumulate per accepted input, so a single instance evaluates any neuron of any layer: fan-in, data width and fraction width are parameters, and the neuron index selects the weight/bias rows. Inputs stream in over a valid/ready handshake. Weights and bias come from external synchronous memories (the `regfile_weight*` / `regfile_bias*` stores). The biased, saturated and optionally rectified result leaves on a valid/ready output.

## Interface
- DATA_W, 16: width of data, weights, bias and result; signed two's complement.
- FRAC_BITS, 8: fractional bits of the Q format used by all of the above.
- N_INPUTS, 784: fan-in; must be ≥ 1.
- NEURON_ID_W, 8: neuron index width.
- ACC_W, 48: accumulator width; must be ≥ 2*DATA_W + $clog2(N_INPUTS) + 1.
- IDX_W, $clog2(N_INPUTS) (minimum 1): derived; input index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a neuron evaluation; honoured only in IDLE.
- neuron_id  in  NEURON_ID_W  neuron index; captured on an accepted start.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample.
- in_data  in  DATA_W  input activation.
- wt_en  out  1  weight read strobe.
- wt_addr  out  NEURON_ID_W+IDX_W  {neuron_id, idx}.
- wt_data  in  DATA_W  weight; valid the cycle after wt_en.
- bias_en  out  1  bias read strobe.
- bias_addr  out  NEURON_ID_W  captured neuron_id.
- bias_data  in  DATA_W  bias; valid the cycle after bias_en.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  neuron output.
- out_sat  out  1  result was saturated; qualified by out_valid.
- busy  out  1  state ≠ IDLE.

## Operation
- **IDLE**
  - start=1: capture neuron_id, clear acc, idx=0, go to ACCUM.
- **ACCUM**
  - in_ready=1.
  - On each handshake (in_valid & in_ready):
    - wt_en=1 and wt_addr={nid, idx} in the same cycle.
    - in_data is registered and a MAC is marked pending.
    - idx increments.
  - A pending MAC completes the next cycle: acc += sext(d_reg*wt_data), a 2*DATA_W signed product, modulo ACC_W.
  - A handshake with idx = N_INPUTS-1 moves the state to DRAIN.
- **DRAIN**
  - in_ready=0.
  - The last pending MAC completes.
  - bias_en=1 and bias_addr=nid.
  - Go to BIAS.
- **BIAS**
  - s = acc + (sext(bias_data) << FRAC_BITS).
  - r = s >>> FRAC_BITS (arithmetic, truncation toward −∞).
  - r is saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; out_sat is set if clamped.
  - The activation is applied (see Configuration).
  - out_data and out_sat are registered; go to DONE.
- **DONE**
  - out_valid=1; out_data and out_sat are held stable.
  - On out_ready, go to IDLE.
- start is ignored in every state other than IDLE, including the DONE→IDLE handshake cycle.
- in_valid outside ACCUM is ignored (in_ready=0).
- wt_en and bias_en are 0 except as stated above.
- Reset:
  - Values: state=IDLE, acc=0, idx=0, pending=0.
  - Outputs: out_valid=0, out_data=0, out_sat=0, in_ready=0, wt_en=0, bias_en=0, busy=0, wt_addr=0, bias_addr=0.
  - Reset mid-evaluation abandons the evaluation with no output and no further memory reads.

## Timing
- Start accepted in cycle 0; ACCUM begins in cycle 1.
- Last input handshake at cycle T:
  - T+1: DRAIN.
  - T+2: BIAS.
  - T+3: out_valid=1.
- With no input stalls, out_valid rises in cycle N_INPUTS+3.
- Input throughput is one sample per cycle; gaps in in_valid only delay completion.
- Output backpressure holds DONE indefinitely.
- Back-to-back evaluations: the next start is honoured no earlier than the cycle after the out handshake.

## Configuration
- NEURON_RELU_EN
  - Defined: negative saturated results become 0 (hidden layers). out_sat still reflects saturation before ReLU.
  - Undefined: linear output, saturated value passed through (output layer).

## Test plan
- N_INPUTS=4, FRAC_BITS=8; inputs 0x0100, weights 0x0080, bias 0x0040; no stalls → out_data=0x0240, out_sat=0, out_valid in cycle 7, wt_addr idx sequence 0,1,2,3.
- Same, weights 0xFF80 → 0x0000 with NEURON_RELU_EN; 0xFE40 without.
- Inputs 0x7FFF, weights 0x7FFF, bias 0x7FFF → out_data=0x7FFF, out_sat=1. Weights 0x8000 without RELU → 0x8000, out_sat=1.
- Stall pattern on in_valid, out_ready low for 5 cycles → same result as the unstalled run; out_data stable while held; start pulses during busy are ignored.
- Reset asserted in ACCUM after 2 samples, then a fresh start → no out_valid from the aborted run; second result correct (acc cleared).
- N_INPUTS=1, neuron_id=0xA5 → wt_addr={0xA5,0}, bias_addr=0xA5, out_valid in cycle 4.
